// File: rtl/hpu_pkg.sv
// hpu_pkg: shared types for the ALU dispatch path and the checkpoint kill rule used by the issue queues
package hpu_pkg;
  localparam int ALU_IQ_INDEX = 3;
  typedef logic [5:0] phy_idx_t;
  typedef logic [2:0] ckpt_t;
  typedef enum logic {FLY = 1'b0, READY = 1'b1} sr_status_e;
  typedef struct packed {
    logic     en;
    phy_idx_t rdst_index;
  } awake_index_t;
  typedef struct packed {
    logic  en;
    ckpt_t ckpt;
  } update_ckpt_t;
  typedef struct packed {
    logic [31:0] pc;
    logic [3:0]  op;
    phy_idx_t    phy_rd_index;
    phy_idx_t    phy_rs1_index;
    phy_idx_t    phy_rs2_index;
    ckpt_t       ckpt;
  } alu_inst_t;
  // An instruction is younger than the recovery point when its checkpoint lies in [rcov, prefetch] circularly
  function automatic logic chk_ckpt(input ckpt_t c, input ckpt_t r, input ckpt_t p);
    return ckpt_t'(c - r) <= ckpt_t'(p - r);
  endfunction
endpackage

// File: rtl/hpu_alu_disp_if.sv
// hpu_alu_disp_if: ID-side, IQ-side, wakeup and recovery signals of the ALU dispatch stage
interface hpu_alu_disp_if;
  import hpu_pkg::*;
  logic                  flush_en_i;
  update_ckpt_t          ckpt_rcov_i;
  ckpt_t                 id__prefet_ckpt_i;
  alu_inst_t             id_disp__inst_i;
  sr_status_e            id_disp__rs1_ready_i;
  sr_status_e            id_disp__rs2_ready_i;
  logic                  id_disp__inst_vld_i;
  logic                  disp_id__inst_rdy_o;
  logic                  alu0_disp__inst_rdy_i;
  logic                  alu1_disp__inst_rdy_i;
  logic [ALU_IQ_INDEX:0] alu0_disp__left_size_i;
  logic [ALU_IQ_INDEX:0] alu1_disp__left_size_i;
  awake_index_t          alu0_iq__awake_i;
  awake_index_t          alu1_iq__awake_i;
  awake_index_t          mdu_iq__awake_i;
  awake_index_t          lsu_iq__awake_i;
  alu_inst_t             disp_alu__inst_o;
  sr_status_e            disp_alu__rs1_ready_o;
  sr_status_e            disp_alu__rs2_ready_o;
  logic                  disp_alu0__inst_vld_o;
  logic                  disp_alu1__inst_vld_o;
  logic [15:0]           disp__stall_cnt_o;
  modport slave (
    input  flush_en_i, ckpt_rcov_i, id__prefet_ckpt_i, id_disp__inst_i, id_disp__rs1_ready_i,
           id_disp__rs2_ready_i, id_disp__inst_vld_i, alu0_disp__inst_rdy_i, alu1_disp__inst_rdy_i,
           alu0_disp__left_size_i, alu1_disp__left_size_i, alu0_iq__awake_i, alu1_iq__awake_i,
           mdu_iq__awake_i, lsu_iq__awake_i,
    output disp_id__inst_rdy_o, disp_alu__inst_o, disp_alu__rs1_ready_o, disp_alu__rs2_ready_o,
           disp_alu0__inst_vld_o, disp_alu1__inst_vld_o, disp__stall_cnt_o
  );
  modport master (
    output flush_en_i, ckpt_rcov_i, id__prefet_ckpt_i, id_disp__inst_i, id_disp__rs1_ready_i,
           id_disp__rs2_ready_i, id_disp__inst_vld_i, alu0_disp__inst_rdy_i, alu1_disp__inst_rdy_i,
           alu0_disp__left_size_i, alu1_disp__left_size_i, alu0_iq__awake_i, alu1_iq__awake_i,
           mdu_iq__awake_i, lsu_iq__awake_i,
    input  disp_id__inst_rdy_o, disp_alu__inst_o, disp_alu__rs1_ready_o, disp_alu__rs2_ready_o,
           disp_alu0__inst_vld_o, disp_alu1__inst_vld_o, disp__stall_cnt_o
  );
endinterface

// File: rtl/hpu_alu_disp.sv
// hpu_alu_disp: two-entry age-ordered dispatch buffer steering ALU instructions to the emptier issue queue
module hpu_alu_disp
  import hpu_pkg::*;
(
  input logic           clk_i,
  input logic           rst_i,
  hpu_alu_disp_if.slave bus
);
  alu_inst_t          r_inst [2];
  sr_status_e         r_rs1 [2];
  sr_status_e         r_rs2 [2];
  logic [1:0]         r_vld;
  logic [1:0]         r_cnt;
  logic               r_rr;
  logic [15:0]        r_stall;
  awake_index_t [3:0] w_aw;
  logic               w_rdy0, w_rdy1, w_kill_any, w_tie, w_sel1, w_disp, w_enq, w_stall;
  logic [1:0]         w_kill;
  sr_status_e         w_in_rs1, w_in_rs2;
  sr_status_e         w_wk_rs1 [2];
  sr_status_e         w_wk_rs2 [2];
  alu_inst_t          w_n_inst [2];
  sr_status_e         w_n_rs1 [2];
  sr_status_e         w_n_rs2 [2];
  logic [1:0]         w_n_vld, w_n_cnt;

  function automatic sr_status_e wake(input sr_status_e s, input phy_idx_t idx, input awake_index_t [3:0] aw);
    logic hit;
    hit = 1'b0;
    for (int k = 0; k < 4; k++) hit = hit | (aw[k].en && aw[k].rdst_index == idx);
    return hit ? READY : s;
  endfunction

  assign w_aw       = {bus.lsu_iq__awake_i, bus.mdu_iq__awake_i, bus.alu1_iq__awake_i, bus.alu0_iq__awake_i};
  assign w_rdy0     = bus.alu0_disp__inst_rdy_i;
  assign w_rdy1     = bus.alu1_disp__inst_rdy_i;
  assign w_kill_any = bus.flush_en_i || bus.ckpt_rcov_i.en;
  assign w_tie      = w_rdy0 && w_rdy1 && bus.alu0_disp__left_size_i == bus.alu1_disp__left_size_i;
  assign w_sel1     = (w_rdy0 && w_rdy1) ? (w_tie ? r_rr : bus.alu1_disp__left_size_i > bus.alu0_disp__left_size_i) : w_rdy1;
  assign w_disp     = r_vld[0] && !w_kill_any && (w_rdy0 || w_rdy1);
  assign w_enq      = bus.id_disp__inst_vld_i && r_cnt != 2'd2 && !w_kill_any;
  assign w_stall    = r_vld[0] && !w_kill_any && !w_rdy0 && !w_rdy1 && r_stall != 16'hffff;
  assign w_in_rs1   = wake(bus.id_disp__rs1_ready_i, bus.id_disp__inst_i.phy_rs1_index, w_aw);
  assign w_in_rs2   = wake(bus.id_disp__rs2_ready_i, bus.id_disp__inst_i.phy_rs2_index, w_aw);

  assign bus.disp_id__inst_rdy_o   = r_cnt != 2'd2;
  assign bus.disp_alu__inst_o      = r_inst[0];
  assign bus.disp_alu__rs1_ready_o = r_rs1[0];
  assign bus.disp_alu__rs2_ready_o = r_rs2[0];
  assign bus.disp_alu0__inst_vld_o = w_disp && !w_sel1;
  assign bus.disp_alu1__inst_vld_o = w_disp && w_sel1;
  assign bus.disp__stall_cnt_o     = r_stall;

  always_comb begin
    for (int i = 0; i < 2; i++) begin
      w_kill[i]   = r_vld[i] && chk_ckpt(r_inst[i].ckpt, bus.ckpt_rcov_i.ckpt, bus.id__prefet_ckpt_i);
      w_wk_rs1[i] = r_vld[i] ? wake(r_rs1[i], r_inst[i].phy_rs1_index, w_aw) : r_rs1[i];
      w_wk_rs2[i] = r_vld[i] ? wake(r_rs2[i], r_inst[i].phy_rs2_index, w_aw) : r_rs2[i];
    end
    w_n_inst = r_inst;
    w_n_rs1  = w_wk_rs1;
    w_n_rs2  = w_wk_rs2;
    w_n_vld  = r_vld;
    w_n_cnt  = r_cnt;
    if (bus.flush_en_i) begin
      w_n_vld = '0;
      w_n_cnt = '0;
    end else if (bus.ckpt_rcov_i.en) begin
      // A killed head takes everything younger with it
      w_n_vld[0] = r_vld[0] && !w_kill[0];
      w_n_vld[1] = w_n_vld[0] && r_vld[1] && !w_kill[1];
      w_n_cnt    = {1'b0, w_n_vld[0]} + {1'b0, w_n_vld[1]};
    end else begin
      if (w_disp) begin
        w_n_inst[0] = r_inst[1];
        w_n_rs1[0]  = w_wk_rs1[1];
        w_n_rs2[0]  = w_wk_rs2[1];
        w_n_vld     = {1'b0, r_vld[1]};
        w_n_cnt     = r_cnt - 2'd1;
      end
      if (w_enq) begin
        w_n_inst[w_n_cnt[0]] = bus.id_disp__inst_i;
        w_n_rs1[w_n_cnt[0]]  = w_in_rs1;
        w_n_rs2[w_n_cnt[0]]  = w_in_rs2;
        w_n_vld[w_n_cnt[0]]  = 1'b1;
        w_n_cnt              = w_n_cnt + 2'd1;
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_inst  <= '{default: '0};
      r_rs1   <= '{default: FLY};
      r_rs2   <= '{default: FLY};
      r_vld   <= '0;
      r_cnt   <= '0;
      r_rr    <= 1'b0;
      r_stall <= '0;
    end else begin
      r_inst <= w_n_inst;
      r_rs1  <= w_n_rs1;
      r_rs2  <= w_n_rs2;
      r_vld  <= w_n_vld;
      r_cnt  <= w_n_cnt;
      if (w_disp && w_tie) r_rr <= !r_rr;
      if (w_stall) r_stall <= r_stall + 16'd1;
    end
  end
endmodule

// File: tb/tb_hpu_alu_disp.sv
// tb_hpu_alu_disp: directed steering, wakeup, recovery, flush and reset checks for hpu_alu_disp
module tb_hpu_alu_disp;
  import hpu_pkg::*;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int checks = 0;
  int errors = 0;
  alu_inst_t a, b, c, d, f, g, h, i1, j, k, l, m, n, p, q, r;

  hpu_alu_disp_if bus();
  hpu_alu_disp dut (.clk_i(clk), .rst_i(rst), .bus(bus));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] o, input logic [63:0] e);
    checks++;
    assert (o === e) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, o, e);
    end
  endtask

  task automatic cyc;
    @(posedge clk);
    #1;
  endtask

  function automatic alu_inst_t mk(input logic [31:0] pc, input phy_idx_t s1, input phy_idx_t s2, input ckpt_t ck);
    return '{pc: pc, op: 4'h3, phy_rd_index: 6'h3f, phy_rs1_index: s1, phy_rs2_index: s2, ckpt: ck};
  endfunction

  task automatic set_rdy(input logic r0, input logic r1, input logic [3:0] s0, input logic [3:0] s1);
    bus.alu0_disp__inst_rdy_i  = r0;
    bus.alu1_disp__inst_rdy_i  = r1;
    bus.alu0_disp__left_size_i = s0;
    bus.alu1_disp__left_size_i = s1;
  endtask

  task automatic send(input logic v, input alu_inst_t x);
    bus.id_disp__inst_vld_i = v;
    bus.id_disp__inst_i     = x;
  endtask

  initial begin
    a = mk(32'h100, 6'h30, 6'h31, 3'd0);
    b = mk(32'h104, 6'h30, 6'h31, 3'd0);
    c = mk(32'h108, 6'h30, 6'h31, 3'd0);
    d = mk(32'h10c, 6'h30, 6'h31, 3'd0);
    f = mk(32'h110, 6'h30, 6'h31, 3'd0);
    g = mk(32'h114, 6'h30, 6'h05, 3'd0);
    h = mk(32'h118, 6'h12, 6'h31, 3'd1);
    i1 = mk(32'h11c, 6'h30, 6'h31, 3'd2);
    j = mk(32'h120, 6'h30, 6'h31, 3'd2);
    k = mk(32'h124, 6'h30, 6'h31, 3'd2);
    l = mk(32'h128, 6'h30, 6'h31, 3'd3);
    m = mk(32'h12c, 6'h30, 6'h31, 3'd3);
    n = mk(32'h130, 6'h30, 6'h31, 3'd3);
    p = mk(32'h134, 6'h30, 6'h31, 3'd3);
    q = mk(32'h138, 6'h30, 6'h31, 3'd3);
    r = mk(32'h13c, 6'h30, 6'h31, 3'd3);
    bus.flush_en_i           = 1'b0;
    bus.ckpt_rcov_i          = '0;
    bus.id__prefet_ckpt_i    = 3'd3;
    bus.id_disp__rs1_ready_i = READY;
    bus.id_disp__rs2_ready_i = READY;
    bus.alu0_iq__awake_i     = '0;
    bus.alu1_iq__awake_i     = '0;
    bus.mdu_iq__awake_i      = '0;
    bus.lsu_iq__awake_i      = '0;
    send(1'b0, '0);
    set_rdy(1'b0, 1'b0, 4'd8, 4'd8);
    cyc();
    cyc();
    rst = 1'b0;
    #1;
    chk("reset_rdy", 64'(bus.disp_id__inst_rdy_o), 64'd1);
    chk("reset_vld0", 64'(bus.disp_alu0__inst_vld_o), 64'd0);
    chk("reset_vld1", 64'(bus.disp_alu1__inst_vld_o), 64'd0);
    chk("reset_inst", 64'(bus.disp_alu__inst_o), 64'd0);
    chk("reset_rs1", 64'(bus.disp_alu__rs1_ready_o), 64'(FLY));
    chk("reset_stall", 64'(bus.disp__stall_cnt_o), 64'd0);

    // tie round-robin: A->alu0, B->alu1, C->alu0
    set_rdy(1'b1, 1'b1, 4'd8, 4'd8);
    send(1'b1, a);
    #1;
    chk("tie_empty_vld0", 64'(bus.disp_alu0__inst_vld_o), 64'd0);
    cyc();
    send(1'b1, b);
    #1;
    chk("tie_a_vld0", 64'(bus.disp_alu0__inst_vld_o), 64'd1);
    chk("tie_a_vld1", 64'(bus.disp_alu1__inst_vld_o), 64'd0);
    chk("tie_a_inst", 64'(bus.disp_alu__inst_o), 64'(a));
    cyc();
    send(1'b1, c);
    #1;
    chk("tie_b_vld0", 64'(bus.disp_alu0__inst_vld_o), 64'd0);
    chk("tie_b_vld1", 64'(bus.disp_alu1__inst_vld_o), 64'd1);
    chk("tie_b_inst", 64'(bus.disp_alu__inst_o), 64'(b));
    cyc();
    send(1'b0, '0);
    #1;
    chk("tie_c_vld0", 64'(bus.disp_alu0__inst_vld_o), 64'd1);
    chk("tie_c_inst", 64'(bus.disp_alu__inst_o), 64'(c));
    cyc();
    #1;
    chk("tie_done_vld0", 64'(bus.disp_alu0__inst_vld_o), 64'd0);
    chk("tie_done_vld1", 64'(bus.disp_alu1__inst_vld_o), 64'd0);

    // imbalance: rr_ptr is now 1 and must survive a non-tie dispatch
    set_rdy(1'b1, 1'b1, 4'd3, 4'd7);
    send(1'b1, d);
    cyc();
    send(1'b1, f);
    #1;
    chk("imb_d_vld1", 64'(bus.disp_alu1__inst_vld_o), 64'd1);
    chk("imb_d_vld0", 64'(bus.disp_alu0__inst_vld_o), 64'd0);
    cyc();
    send(1'b0, '0);
    set_rdy(1'b1, 1'b1, 4'd8, 4'd8);
    #1;
    chk("imb_rr_kept_vld1", 64'(bus.disp_alu1__inst_vld_o), 64'd1);
    chk("imb_rr_kept_inst", 64'(bus.disp_alu__inst_o), 64'(f));
    cyc();
    // alu1 full, incoming rs2 woken by alu0 bus during enqueue
    send(1'b1, g);
    bus.id_disp__rs2_ready_i = FLY;
    bus.alu0_iq__awake_i     = '{en: 1'b1, rdst_index: 6'h05};
    cyc();
    send(1'b0, '0);
    bus.id_disp__rs2_ready_i = READY;
    bus.alu0_iq__awake_i     = '0;
    set_rdy(1'b1, 1'b0, 4'd3, 4'd7);
    #1;
    chk("bp_rs2_in_wake", 64'(bus.disp_alu__rs2_ready_o), 64'(READY));
    chk("bp_vld0", 64'(bus.disp_alu0__inst_vld_o), 64'd1);
    chk("bp_vld1", 64'(bus.disp_alu1__inst_vld_o), 64'd0);
    cyc();

    // stall with both queues full, plus wakeup of buffered head
    set_rdy(1'b0, 1'b0, 4'd0, 4'd0);
    send(1'b1, h);
    bus.id_disp__rs1_ready_i = FLY;
    cyc();
    send(1'b1, i1);
    bus.id_disp__rs1_ready_i = READY;
    cyc();
    send(1'b1, j);
    bus.mdu_iq__awake_i = '{en: 1'b1, rdst_index: 6'h12};
    #1;
    chk("full_rdy", 64'(bus.disp_id__inst_rdy_o), 64'd0);
    chk("wake_before", 64'(bus.disp_alu__rs1_ready_o), 64'(FLY));
    chk("stall_vld0", 64'(bus.disp_alu0__inst_vld_o), 64'd0);
    chk("stall_vld1", 64'(bus.disp_alu1__inst_vld_o), 64'd0);
    cyc();
    send(1'b0, '0);
    bus.mdu_iq__awake_i = '0;
    #1;
    chk("wake_after", 64'(bus.disp_alu__rs1_ready_o), 64'(READY));
    cyc();
    cyc();
    cyc();
    chk("stall_cnt5", 64'(bus.disp__stall_cnt_o), 64'd5);
    chk("stall_full_rdy", 64'(bus.disp_id__inst_rdy_o), 64'd0);
    chk("stall_head", 64'(bus.disp_alu__inst_o), 64'(h));

    // recovery to ckpt 2 kills only the young entry
    set_rdy(1'b1, 1'b1, 4'd8, 4'd8);
    bus.ckpt_rcov_i = '{en: 1'b1, ckpt: 3'd2};
    #1;
    chk("rcov_vld0", 64'(bus.disp_alu0__inst_vld_o), 64'd0);
    chk("rcov_vld1", 64'(bus.disp_alu1__inst_vld_o), 64'd0);
    cyc();
    bus.ckpt_rcov_i = '0;
    #1;
    chk("rcov_cnt1_rdy", 64'(bus.disp_id__inst_rdy_o), 64'd1);
    chk("rcov_old_vld0", 64'(bus.disp_alu0__inst_vld_o), 64'd1);
    chk("rcov_old_inst", 64'(bus.disp_alu__inst_o), 64'(h));
    chk("rcov_no_stall", 64'(bus.disp__stall_cnt_o), 64'd5);
    cyc();
    chk("rcov_drained0", 64'(bus.disp_alu0__inst_vld_o), 64'd0);
    chk("rcov_drained1", 64'(bus.disp_alu1__inst_vld_o), 64'd0);

    // recovery that kills the head empties the buffer
    set_rdy(1'b0, 1'b0, 4'd0, 4'd0);
    send(1'b1, k);
    cyc();
    send(1'b1, l);
    cyc();
    send(1'b0, '0);
    set_rdy(1'b1, 1'b1, 4'd8, 4'd8);
    bus.ckpt_rcov_i = '{en: 1'b1, ckpt: 3'd2};
    #1;
    chk("rcov2_vld0", 64'(bus.disp_alu0__inst_vld_o), 64'd0);
    chk("rcov2_vld1", 64'(bus.disp_alu1__inst_vld_o), 64'd0);
    cyc();
    bus.ckpt_rcov_i = '0;
    #1;
    chk("rcov2_empty_vld0", 64'(bus.disp_alu0__inst_vld_o), 64'd0);
    chk("rcov2_empty_vld1", 64'(bus.disp_alu1__inst_vld_o), 64'd0);
    chk("rcov2_rdy", 64'(bus.disp_id__inst_rdy_o), 64'd1);
    chk("rcov2_inst_kept", 64'(bus.disp_alu__inst_o), 64'(k));

    // flush with a valid input in the same cycle
    set_rdy(1'b0, 1'b0, 4'd0, 4'd0);
    send(1'b1, m);
    cyc();
    send(1'b1, n);
    bus.flush_en_i = 1'b1;
    set_rdy(1'b1, 1'b1, 4'd8, 4'd8);
    #1;
    chk("flush_vld0", 64'(bus.disp_alu0__inst_vld_o), 64'd0);
    chk("flush_vld1", 64'(bus.disp_alu1__inst_vld_o), 64'd0);
    cyc();
    bus.flush_en_i = 1'b0;
    send(1'b0, '0);
    #1;
    chk("flush_rdy", 64'(bus.disp_id__inst_rdy_o), 64'd1);
    chk("flush_drop_vld0", 64'(bus.disp_alu0__inst_vld_o), 64'd0);
    chk("flush_drop_vld1", 64'(bus.disp_alu1__inst_vld_o), 64'd0);
    chk("flush_inst_kept", 64'(bus.disp_alu__inst_o), 64'(m));
    chk("flush_stall_kept", 64'(bus.disp__stall_cnt_o), 64'd6);

    // asynchronous reset mid-stream, no clock edge
    set_rdy(1'b0, 1'b0, 4'd0, 4'd0);
    send(1'b1, p);
    cyc();
    send(1'b1, q);
    cyc();
    send(1'b0, '0);
    #1;
    chk("pre_rst_stall", 64'(bus.disp__stall_cnt_o), 64'd7);
    chk("pre_rst_full", 64'(bus.disp_id__inst_rdy_o), 64'd0);
    set_rdy(1'b1, 1'b1, 4'd8, 4'd8);
    rst = 1'b1;
    #1;
    chk("arst_rdy", 64'(bus.disp_id__inst_rdy_o), 64'd1);
    chk("arst_vld0", 64'(bus.disp_alu0__inst_vld_o), 64'd0);
    chk("arst_vld1", 64'(bus.disp_alu1__inst_vld_o), 64'd0);
    chk("arst_inst", 64'(bus.disp_alu__inst_o), 64'd0);
    chk("arst_rs1", 64'(bus.disp_alu__rs1_ready_o), 64'(FLY));
    chk("arst_stall", 64'(bus.disp__stall_cnt_o), 64'd0);
    rst = 1'b0;
    cyc();

    // stall counter saturation
    set_rdy(1'b0, 1'b0, 4'd0, 4'd0);
    send(1'b1, r);
    cyc();
    send(1'b0, '0);
    repeat (65540) cyc();
    chk("stall_sat", 64'(bus.disp__stall_cnt_o), 64'hffff);
    set_rdy(1'b0, 1'b1, 4'd0, 4'd2);
    #1;
    chk("sat_vld1", 64'(bus.disp_alu1__inst_vld_o), 64'd1);
    chk("sat_inst", 64'(bus.disp_alu__inst_o), 64'(r));
    cyc();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
